// File: rtl/seqcheck_pkg.sv
// Shared types and helpers for the multi-channel sliding-window edge monitor.
package seqcheck_pkg;

   // Event type, common to all channels.
   typedef enum logic [1:0] {
      EDGE_RISE = 2'b00,
      EDGE_FALL = 2'b01,
      EDGE_BOTH = 2'b10,
      EDGE_OFF  = 2'b11
   } edge_mode_e;

   // Width needed to hold a count of 0..w inclusive.
   function automatic int cnt_width(input int w);
      return $clog2(w + 1);
   endfunction

endpackage

// File: rtl/seqcheck_chan.sv
// One monitor channel: synchroniser, edge select, W-slot ring buffer with a
// running sum, and the registered above/hit threshold outputs.
module seqcheck_chan
   import seqcheck_pkg::*;
#(
   parameter int W     = 8,
   parameter int CNT_W = cnt_width(W),
   parameter int IDX_W = $clog2(W)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_sig_i,
   input  edge_mode_e       edge_mode_i,
   input  logic [CNT_W-1:0] thresh_i,
   input  logic             clear_i,
   input  logic [IDX_W-1:0] idx_i,
   output logic [CNT_W-1:0] count_o,
   output logic             above_o,
   output logic             hit_o,
   output logic             hit_next_o
);

   logic             s1_q, s2_q, prev_q;
   logic [W-1:0]     rb_q, rb_d;
   logic [CNT_W-1:0] sum_q, sum_d;
   logic [CNT_W-1:0] next_sum;
   logic             above_q, above_d;
   logic             hit_q, hit_d;
   logic             ev;
   logic             cond;

   // Two-flop synchroniser plus previous sample; clear leaves these alone so
   // no spurious edge is seen after a clear.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state is written with non-blocking assignments only.
      if (rst) begin
         s1_q   <= 1'b0;
         s2_q   <= 1'b0;
         prev_q <= 1'b0;
      end else begin
         s1_q   <= in_sig_i;
         s2_q   <= s1_q;
         prev_q <= s2_q;
      end
   end

   // Select the event type from the synchronised level and its last value.
   always_comb begin
      // NOTE: every combinational output gets a default first so no latch is inferred.
      ev = 1'b0;
      case (edge_mode_i)
         EDGE_RISE: ev = s2_q & ~prev_q;
         EDGE_FALL: ev = ~s2_q & prev_q;
         EDGE_BOTH: ev = s2_q ^ prev_q;
         default:   ev = 1'b0;
      endcase
   end

   // Slide the window: retire the slot at idx, insert the new event, and
   // evaluate the threshold against the updated sum. Clear wins over events.
   always_comb begin
      rb_d     = rb_q;
      next_sum = sum_q - CNT_W'(rb_q[idx_i]) + CNT_W'(ev);
      cond     = (thresh_i != '0) && (next_sum >= thresh_i);
      rb_d[idx_i] = ev;
      sum_d    = next_sum;
      above_d  = cond;
      hit_d    = cond & ~above_q;
      if (clear_i) begin
         rb_d    = '0;
         sum_d   = '0;
         above_d = 1'b0;
         hit_d   = 1'b0;
      end
   end

   // Window state and threshold outputs.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: the ring buffer is a handful of flops, not a RAM, so it is reset
      // with the rest of the state and needs no init sweep.
      if (rst) begin
         rb_q    <= '0;
         sum_q   <= '0;
         above_q <= 1'b0;
         hit_q   <= 1'b0;
      end else begin
         rb_q    <= rb_d;
         sum_q   <= sum_d;
         above_q <= above_d;
         hit_q   <= hit_d;
      end
   end

   assign count_o    = sum_q;
   assign above_o    = above_q;
   assign hit_o      = hit_q;
   assign hit_next_o = hit_d;

endmodule

// File: rtl/seqcheck_multi.sv
// Multi-channel sliding-window edge monitor: shared window index, N_CH
// independent channels and a registered any-hit summary.
module seqcheck_multi
   import seqcheck_pkg::*;
#(
   parameter int N_CH  = 4,
   parameter int W     = 8,
   parameter int CNT_W = cnt_width(W)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [N_CH-1:0]       in_sig,
   input  logic [1:0]            edge_mode,
   input  logic [CNT_W-1:0]      thresh,
   input  logic                  clear,
   output logic [N_CH-1:0]       hit,
   output logic [N_CH-1:0]       above,
   output logic [N_CH*CNT_W-1:0] count,
   output logic                  any_hit
);

   localparam int                IDX_W    = $clog2(W);
   localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(W - 1);

   logic [IDX_W-1:0] idx_q, idx_d;
   logic [N_CH-1:0]  hit_next;
   logic             any_hit_q, any_hit_d;
   edge_mode_e       mode;

   assign mode = edge_mode_e'(edge_mode);

   // Window index walks 0..W-1 every cycle; clear restarts it at slot 0.
   always_comb begin
      idx_d = idx_q + 1'b1;
      if (clear || (idx_q == IDX_LAST)) begin
         idx_d = '0;
      end
      any_hit_d = |hit_next;
   end

   // Shared index and the any-hit flop, registered alongside each channel hit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx_q     <= '0;
         any_hit_q <= 1'b0;
      end else begin
         idx_q     <= idx_d;
         any_hit_q <= any_hit_d;
      end
   end

   for (genvar c = 0; c < N_CH; c++) begin : g_ch
      seqcheck_chan #(
         .W     (W),
         .CNT_W (CNT_W),
         .IDX_W (IDX_W)
      ) u_chan (
         .clk        (clk),
         .rst        (rst),
         .in_sig_i   (in_sig[c]),
         .edge_mode_i(mode),
         .thresh_i   (thresh),
         .clear_i    (clear),
         .idx_i      (idx_q),
         .count_o    (count[c*CNT_W +: CNT_W]),
         .above_o    (above[c]),
         .hit_o      (hit[c]),
         .hit_next_o (hit_next[c])
      );
   end

   assign any_hit = any_hit_q;

endmodule

// File: tb/tb_seqcheck_multi.sv
// Scoreboard bench for seqcheck_multi (N_CH=4, W=5). Stimulus pushes
// cycle-tagged expectations; the monitor samples on every falling edge (and
// on an explicit probe for asynchronous reset) and retires due entries.
module tb_seqcheck_multi;
   import seqcheck_pkg::*;

   localparam int N_CH  = 4;
   localparam int W     = 5;
   localparam int CNT_W = cnt_width(W);

   logic                  clk = 1'b0;
   logic                  rst = 1'b1;
   logic [N_CH-1:0]       in_sig = '0;
   logic [1:0]            edge_mode = 2'b00;
   logic [CNT_W-1:0]      thresh = 3'd3;
   logic                  clear = 1'b0;
   logic [N_CH-1:0]       hit;
   logic [N_CH-1:0]       above;
   logic [N_CH*CNT_W-1:0] count;
   logic                  any_hit;

   seqcheck_multi #(.N_CH(N_CH), .W(W)) dut (
      .clk      (clk),
      .rst      (rst),
      .in_sig   (in_sig),
      .edge_mode(edge_mode),
      .thresh   (thresh),
      .clear    (clear),
      .hit      (hit),
      .above    (above),
      .count    (count),
      .any_hit  (any_hit)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef enum {K_COUNT, K_HIT, K_ABOVE, K_ANY} kind_e;
   typedef struct {
      int    cyc;
      kind_e kind;
      int    ch;
      int    exp;
      string name;
   } exp_t;

   exp_t sb_q[$];
   exp_t probe_q[$];
   exp_t keep_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   event probe_ev;

   function automatic int actual(kind_e k, int ch);
      case (k)
         K_COUNT: return int'(count[ch*CNT_W +: CNT_W]);
         K_HIT:   return int'(hit);
         K_ABOVE: return int'(above);
         default: return int'(any_hit);
      endcase
   endfunction

   task automatic check(string name, int act, int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: actual %0d required %0d (cycle %0d)", name, act, exp, cyc);
   endtask

   function automatic void exp_at(int d, kind_e k, int ch, int v, string name);
      exp_t e;
      e.cyc = cyc + d; e.kind = k; e.ch = ch; e.exp = v; e.name = name;
      sb_q.push_back(e);
   endfunction

   function automatic void quiet(int d0, int d1, string name);
      for (int d = d0; d <= d1; d++) begin
         exp_at(d, K_HIT, 0, 0, name);
         exp_at(d, K_ANY, 0, 0, name);
      end
   endfunction

   function automatic void probe_zero(string name);
      exp_t e;
      e.cyc = cyc; e.ch = 0; e.exp = 0; e.name = name;
      for (int c = 0; c < N_CH; c++) begin
         e.kind = K_COUNT; e.ch = c; probe_q.push_back(e);
      end
      e.ch = 0;
      e.kind = K_HIT;   probe_q.push_back(e);
      e.kind = K_ABOVE; probe_q.push_back(e);
      e.kind = K_ANY;   probe_q.push_back(e);
   endfunction

   task automatic step(int n);
      repeat (n) @(negedge clk);
   endtask

   // Monitor: retire expectations due now; probes cover async reset.
   initial begin : monitor
      forever begin
         @(negedge clk or probe_ev);
         if (probe_q.size() != 0) begin
            foreach (probe_q[i]) check(probe_q[i].name, actual(probe_q[i].kind, probe_q[i].ch), probe_q[i].exp);
            probe_q.delete();
         end else begin
            keep_q.delete();
            foreach (sb_q[i]) begin
               if (sb_q[i].cyc == cyc) begin
                  check(sb_q[i].name, actual(sb_q[i].kind, sb_q[i].ch), sb_q[i].exp);
               end else if (sb_q[i].cyc < cyc) begin
                  n_checks++;
                  $display("FAIL %s: expectation for cycle %0d never sampled", sb_q[i].name, sb_q[i].cyc);
               end else begin
                  keep_q.push_back(sb_q[i]);
               end
            end
            sb_q = keep_q;
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: bench did not finish, actual timeout required completion");
      $fatal(1, "timeout");
   end

   initial begin : stim
      // Reset state, observed without any clock edge.
      #1;
      probe_zero("reset_state");
      -> probe_ev;
      step(2);
      rst = 1'b0;

      // 1: rising edges on ch0 two cycles apart, thresh 3.
      step(1);
      exp_at(3, K_COUNT, 0, 1, "s1_count1");
      exp_at(5, K_COUNT, 0, 2, "s1_count2");
      exp_at(7, K_COUNT, 0, 3, "s1_count3");
      quiet(1, 6, "s1_no_early_hit");
      exp_at(7, K_HIT, 0, 1, "s1_hit");
      exp_at(7, K_ANY, 0, 1, "s1_any_hit");
      exp_at(7, K_ABOVE, 0, 1, "s1_above");
      for (int c = 1; c < N_CH; c++) exp_at(7, K_COUNT, c, 0, "s1_other_count");
      quiet(8, 12, "s1_single_pulse");
      exp_at(8, K_COUNT, 0, 2, "s1_oldest_retired");
      exp_at(8, K_ABOVE, 0, 0, "s1_above_drop");
      exp_at(13, K_COUNT, 0, 0, "s1_window_empty");
      for (int k = 0; k < 3; k++) begin
         in_sig[0] = 1'b1; step(1);
         in_sig[0] = 1'b0; step(1);
      end
      step(9);

      // 2: rising edges on ch1 every 3 cycles never reach 3 in a 5-window.
      exp_at(3, K_COUNT, 1, 1, "s2_c3");
      exp_at(5, K_COUNT, 1, 1, "s2_c5");
      exp_at(6, K_COUNT, 1, 2, "s2_c6");
      exp_at(7, K_COUNT, 1, 2, "s2_c7");
      exp_at(8, K_COUNT, 1, 1, "s2_c8");
      exp_at(9, K_COUNT, 1, 2, "s2_c9");
      exp_at(11, K_COUNT, 1, 1, "s2_c11");
      exp_at(12, K_COUNT, 1, 2, "s2_c12");
      exp_at(14, K_COUNT, 1, 1, "s2_c14");
      exp_at(17, K_COUNT, 1, 0, "s2_c17");
      exp_at(7, K_ABOVE, 0, 0, "s2_above");
      exp_at(12, K_ABOVE, 0, 0, "s2_above");
      quiet(1, 17, "s2_no_hit");
      for (int k = 0; k < 4; k++) begin
         in_sig[1] = 1'b1; step(1);
         in_sig[1] = 1'b0; step(2);
      end
      step(6);

      // 3: both edges, ch2 toggling every cycle, thresh 5.
      edge_mode = 2'b10;
      thresh    = 3'd5;
      exp_at(3, K_COUNT, 2, 1, "s3_c3");
      exp_at(6, K_COUNT, 2, 4, "s3_c6");
      exp_at(7, K_COUNT, 2, 5, "s3_c7");
      exp_at(7, K_HIT, 0, 4, "s3_hit");
      exp_at(7, K_ANY, 0, 1, "s3_any_hit");
      exp_at(7, K_ABOVE, 0, 4, "s3_above7");
      exp_at(10, K_ABOVE, 0, 4, "s3_above10");
      exp_at(12, K_ABOVE, 0, 4, "s3_above12");
      exp_at(12, K_COUNT, 2, 5, "s3_c12");
      exp_at(13, K_COUNT, 2, 4, "s3_c13");
      exp_at(13, K_ABOVE, 0, 0, "s3_above13");
      exp_at(17, K_COUNT, 2, 0, "s3_c17");
      quiet(1, 6, "s3_no_early_hit");
      quiet(8, 17, "s3_no_refire");
      for (int k = 0; k < 10; k++) begin
         in_sig[2] = ~in_sig[2]; step(1);
      end
      step(8);

      // 4: count 2 on ch3, lower thresh to 2, then to 0.
      edge_mode = 2'b00;
      thresh    = 3'd3;
      exp_at(5, K_COUNT, 3, 2, "s4_c5");
      exp_at(6, K_HIT, 0, 8, "s4_hit");
      exp_at(6, K_ANY, 0, 1, "s4_any_hit");
      exp_at(6, K_ABOVE, 0, 8, "s4_above");
      exp_at(7, K_COUNT, 3, 2, "s4_c7");
      exp_at(7, K_ABOVE, 0, 0, "s4_thresh0_above");
      exp_at(8, K_COUNT, 3, 1, "s4_c8");
      exp_at(10, K_COUNT, 3, 0, "s4_c10");
      quiet(1, 5, "s4_no_early_hit");
      quiet(7, 10, "s4_thresh0_no_hit");
      in_sig[3] = 1'b1; step(1);
      in_sig[3] = 1'b0; step(1);
      in_sig[3] = 1'b1; step(1);
      in_sig[3] = 1'b0; step(2);
      thresh = 3'd2;    step(1);
      thresh = 3'd0;    step(1);
      thresh = 3'd3;    step(4);

      // 5a: clear coincides with a ch0 event while the count is 2.
      exp_at(5, K_COUNT, 0, 2, "s5a_c5");
      exp_at(6, K_COUNT, 0, 2, "s5a_c6");
      for (int c = 0; c < N_CH; c++) exp_at(7, K_COUNT, c, 0, "s5a_cleared");
      exp_at(7, K_ABOVE, 0, 0, "s5a_above");
      exp_at(8, K_COUNT, 0, 0, "s5a_event_lost");
      exp_at(10, K_COUNT, 0, 0, "s5a_no_spurious");
      exp_at(16, K_COUNT, 0, 0, "s5a_c16");
      quiet(1, 16, "s5a_no_hit");
      in_sig[0] = 1'b1; step(1);
      in_sig[0] = 1'b0; step(1);
      in_sig[0] = 1'b1; step(1);
      in_sig[0] = 1'b0; step(1);
      in_sig[0] = 1'b1; step(2);
      clear = 1'b1;     step(1);
      clear = 1'b0;     step(4);
      in_sig[0] = 1'b0; step(6);

      // 5b: reset mid-window; ch1 held high across reset counts as a rise.
      exp_at(5, K_COUNT, 1, 2, "s5b_c5");
      exp_at(8, K_COUNT, 1, 0, "s5b_post_rst_c8");
      exp_at(9, K_COUNT, 1, 1, "s5b_post_rst_rise");
      exp_at(14, K_COUNT, 1, 0, "s5b_c14");
      quiet(1, 14, "s5b_no_hit");
      in_sig[1] = 1'b1; step(1);
      in_sig[1] = 1'b0; step(1);
      in_sig[1] = 1'b1; step(3);
      #2;
      rst = 1'b1;
      #1;
      probe_zero("s5b_async_rst");
      -> probe_ev;
      step(1);
      rst = 1'b0;
      step(4);
      in_sig[1] = 1'b0;
      step(5);

      // 6: mode 11 with edges on every channel; buffered event decays out.
      for (int c = 0; c < N_CH; c++) begin
         exp_at(3, K_COUNT, c, 1, "s6_c3");
         exp_at(5, K_COUNT, c, 1, "s6_c5_suppressed");
         exp_at(7, K_COUNT, c, 1, "s6_c7");
         exp_at(8, K_COUNT, c, 0, "s6_decayed");
      end
      quiet(1, 14, "s6_no_hit");
      in_sig = 4'hF;
      for (int k = 1; k <= 10; k++) begin
         step(1);
         in_sig = ~in_sig;
         if (k == 3) edge_mode = 2'b11;
      end
      step(1);
      in_sig = '0;
      step(6);

      foreach (sb_q[i]) begin
         n_checks++;
         $display("FAIL %s: expectation for cycle %0d left pending", sb_q[i].name, sb_q[i].cyc);
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
